// File: rtl/muldiv_if.sv
// Handshake and result bundle between the control unit and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;
    logic             busy;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, ready, busy, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, ready, busy, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide, one bit
// per cycle. Operands are reduced to magnitudes on entry; signs are re-applied
// in a single fix-up cycle before the registered hi/lo are updated.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_sa;
    logic             r_sb;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] r_opnd;
    // {acc_hi, acc_lo}: product accumulator, or {remainder, quotient}.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;
    logic             r_busy;
    logic             r_div_zero;

    // Operand decode, valid only while idle with start asserted.
    logic             w_op_signed;
    logic             w_op_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_div_by_zero;

    assign w_op_signed   = ~bus.op[0];
    assign w_op_div      = bus.op[1];
    assign w_a_neg       = w_op_signed & bus.a[WIDTH-1];
    assign w_b_neg       = w_op_signed & bus.b[WIDTH-1];
    // Most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_a_abs       = w_a_neg ? -bus.a : bus.a;
    assign w_b_abs       = w_b_neg ? -bus.b : bus.b;
    assign w_div_by_zero = w_op_div && (bus.b == '0);

    // Multiply step: conditional add with carry kept in the extra bit.
    logic [WIDTH:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide step: remainder shifted left with the next dividend bit, then trial subtract.
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_ok;
    assign w_rem_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_opnd};
    assign w_trial_ok  = ~w_trial[WIDTH];

    // Sign fix-up; sign flags are zero for unsigned ops so those pass through.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_sa ? -r_acc_hi : r_acc_hi;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; divide by zero skips the datapath entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_div_by_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_ready <= (w_state_next == S_DONE);
            r_busy  <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_div_by_zero) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            r_cnt    <= CNT_W'(WIDTH - 1);
                            r_is_div <= w_op_div;
                            r_sa     <= w_a_neg;
                            r_sb     <= w_b_neg;
                            r_acc_hi <= '0;
                            if (w_op_div) begin
                                r_opnd   <= w_b_abs;
                                r_acc_lo <= w_a_abs;
                            end else begin
                                r_opnd   <= w_a_abs;
                                r_acc_lo <= w_b_abs;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (r_is_div) begin
                        r_acc_hi <= w_trial_ok ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_trial_ok};
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_div_zero <= 1'b0;
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: hi/lo keep their old values on divide by zero.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p = 64'(sa * sb);
                exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0;
            end
            default: begin
                if (b == '0) begin
                    exp_dz = 1'b1;
                end else begin
                    if (op == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'b0, a}) / longint'({32'b0, b});
                        r = longint'({32'b0, a}) % longint'({32'b0, b});
                    end
                    exp_lo = q[31:0]; exp_hi = r[31:0]; exp_dz = 1'b0;
                end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom());
        endcase
    endfunction

    // One transaction: start, optional stray start mid-CALC, wait for ready, check.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit stray);
        int lat;
        int want_lat;
        model(op, a, b);
        want_lat = (op[1] && b == '0) ? 1 : W + 2;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom()); bus.a = W'($urandom()); bus.b = W'($urandom());
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        lat = 1;
        while (!bus.ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (stray && lat == 10) begin
                bus.start = 1'b1; bus.op = 2'($urandom());
                bus.a = W'($urandom()); bus.b = W'($urandom());
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("latency", 64'(lat), 64'(want_lat));
        chk("hi", 64'(bus.hi), 64'(exp_hi));
        chk("lo", 64'(bus.lo), 64'(exp_lo));
        chk("div_zero", 64'(bus.div_zero), 64'(exp_dz));
        @(posedge clk); #1;
        chk("ready_one_cycle", 64'(bus.ready), 64'd0);
        chk("busy_idle", 64'(bus.busy), 64'd0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
                 op, a, b, bus.hi, bus.lo, bus.div_zero, lat);
    endtask

    task automatic reset_mid_calc();
        int rdy_seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_dz", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        rdy_seen = 0;
        repeat (W + 6) begin
            @(posedge clk); #1;
            if (bus.ready) rdy_seen++;
        end
        chk("no_ready_after_abort", 64'(rdy_seen), 64'd0);
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        $display("reset mid-CALC: hi=%h lo=%h ready_pulses=%0d", bus.hi, bus.lo, rdy_seen);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_ready", 64'(bus.ready), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_dz", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed corner cases.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, -32'sd7, 32'd3, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b10, -32'sd7, 32'd2, 1'b0);
        run_op(2'b11, 32'd7, 32'd2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'd95, 32'd10, 1'b0);
        run_op(2'b11, 32'd10, 32'd0, 1'b0);
        run_op(2'b10, 32'd100, 32'd0, 1'b0);
        run_op(2'b00, 32'd6, 32'd7, 1'b0);
        run_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        reset_mid_calc();
        run_op(2'b10, 32'd50, -32'sd6, 1'b0);

        // Randomised operations, some with stray starts during CALC.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom()), pick(), pick(), bit'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
